// File: rtl/kpyd_saw_pkg.sv
// rtl/kpyd_saw_pkg.sv - shared constants and helpers for the keypad sawtooth voice
//
// Purpose : note table, keypad map, default sample rate and the phase
//           increment helper used by kpyd_saw_voice.
// Ports   : none (package).
// Config  : KPYD_SAW_GATE_EN is consumed by kpyd_saw_voice, not here.
package kpyd_saw_pkg;

   localparam int unsigned FS_HZ_DEFAULT = 48000;

   // Note frequencies in Hz, indexed by hex key code.
   localparam int unsigned NOTE_HZ [16] = '{
      261, 294, 330, 349, 392, 440, 494, 523,
      587, 659, 698, 784, 880, 988, 1046, 1174
   };

   // Keypad map indexed by {row_idx, col_idx}.
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   // floor(hz * 2^acc_w / fs), evaluated in 64 bits.
   function automatic logic [63:0] calc_inc(input int unsigned hz,
                                            input int unsigned acc_w,
                                            input int unsigned fs);
      return (64'(hz) << acc_w) / 64'(fs);
   endfunction

endpackage

// File: rtl/phase_accumulator.sv
// rtl/phase_accumulator.sv - free-running phase accumulator
//
// Purpose : acc <= acc + phase_inc every clock, silent modulo wrap.
// Ports   : clk       - sample clock
//           reset     - synchronous, active-high; clears acc
//           phase_inc - increment added each clock
//           addr      - acc MSBs used as waveform address
module phase_accumulator #(
   parameter int ACC_WIDTH  = 32,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ACC_WIDTH-1:0]  phase_inc,
   output logic [ADDR_WIDTH-1:0] addr
);

   logic [ACC_WIDTH-1:0] acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
      end else begin
         acc <= acc + phase_inc;
      end
   end

   assign addr = acc[ACC_WIDTH-1 -: ADDR_WIDTH];

endmodule

// File: rtl/kpyd_saw_voice.sv
// rtl/kpyd_saw_voice.sv - keypad-driven single sawtooth voice
//
// Purpose : decode a one-hot 4x4 keypad code to a hex note, run a phase
//           accumulator at that note's increment, emit a signed sawtooth.
// Ports   : clk_i       - sample clock
//           reset_i     - synchronous, active-high
//           kpyd_i      - {row[3:0], col[3:0]}, active-high
//           hex_o       - latched key code
//           key_valid_o - legal press sampled on the last edge
//           addr_o      - accumulator MSBs
//           data_o      - signed sawtooth sample
//           valid_o     - data_o meaningful (1 from first edge out of reset)
// Config  : KPYD_SAW_GATE_EN - when defined, data_o is forced to 0 on
//           edges where key_valid_o is 0; the accumulator keeps running.
module kpyd_saw_voice
   import kpyd_saw_pkg::*;
#(
   parameter int          ACC_WIDTH  = 32,
   parameter int          ADDR_WIDTH = 9,
   parameter int          WIDTH_P    = 24,
   parameter int unsigned FS_HZ      = FS_HZ_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [7:0]            kpyd_i,
   output logic [3:0]            hex_o,
   output logic                  key_valid_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [WIDTH_P-1:0]    data_o,
   output logic                  valid_o
);

   logic [3:0]           row;
   logic [3:0]           col;
   logic [1:0]           row_idx;
   logic [1:0]           col_idx;
   logic                 legal;
   logic [3:0]           key_code;
   logic [ACC_WIDTH-1:0] inc_tbl [16];
   logic [ACC_WIDTH-1:0] phase_inc;
   logic [WIDTH_P-1:0]   saw_sample;

   assign row = kpyd_i[7:4];
   assign col = kpyd_i[3:0];

   always_comb begin
      row_idx = '0;
      col_idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (row[i]) row_idx = 2'(i);
         if (col[i]) col_idx = 2'(i);
      end
   end

   assign legal    = $onehot(row) && $onehot(col);
   assign key_code = KEY_MAP[{row_idx, col_idx}];

   // Increments are elaboration-time constants; only the 16:1 select is logic.
   for (genvar g = 0; g < 16; g++) begin : g_inc
      assign inc_tbl[g] = ACC_WIDTH'(calc_inc(NOTE_HZ[g], ACC_WIDTH, FS_HZ));
   end

   assign phase_inc = inc_tbl[hex_o];

   phase_accumulator #(
      .ACC_WIDTH  (ACC_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_phase_acc (
      .clk       (clk_i),
      .reset     (reset_i),
      .phase_inc (phase_inc),
      .addr      (addr_o)
   );

   // addr - 2^(ADDR_WIDTH-1) is the address with its MSB inverted, read as
   // two's complement; then left-justified into the sample width.
   assign saw_sample = {~addr_o[ADDR_WIDTH-1], addr_o[ADDR_WIDTH-2:0],
                        {(WIDTH_P-ADDR_WIDTH){1'b0}}};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         hex_o       <= '0;
         key_valid_o <= 1'b0;
         data_o      <= '0;
         valid_o     <= 1'b0;
      end else begin
         if (legal) begin
            hex_o       <= key_code;
            key_valid_o <= 1'b1;
         end else begin
            key_valid_o <= 1'b0;
         end
         valid_o <= 1'b1;
`ifdef KPYD_SAW_GATE_EN
         data_o  <= key_valid_o ? saw_sample : '0;
`else
         data_o  <= saw_sample;
`endif
      end
   end

endmodule

// File: tb/tb_kpyd_saw_voice.sv
// tb/tb_kpyd_saw_voice.sv - self-checking bench for kpyd_saw_voice
module tb_kpyd_saw_voice;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic [7:0]  kpyd_i = 8'h00;
   logic [3:0]  hex_o;
   logic        key_valid_o;
   logic [8:0]  addr_o;
   logic [23:0] data_o;
   logic        valid_o;

   int checks = 0;
   int errors = 0;

   kpyd_saw_voice dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .kpyd_i      (kpyd_i),
      .hex_o       (hex_o),
      .key_valid_o (key_valid_o),
      .addr_o      (addr_o),
      .data_o      (data_o),
      .valid_o     (valid_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model state
   int unsigned       m_hz [16] = '{261, 294, 330, 349, 392, 440, 494, 523,
                                    587, 659, 698, 784, 880, 988, 1046, 1174};
   int                m_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
   int                m_hex;
   bit                m_kv;
   longint unsigned   m_acc;
   logic [23:0]       m_data;
   bit                m_valid;

   function automatic longint unsigned m_inc(input int h);
      return (longint'(m_hz[h]) * 64'd4294967296) / 64'd48000;
   endfunction

   function automatic int m_addr();
      return int'(m_acc / 64'd8388608);
   endfunction

   function automatic logic [23:0] m_saw(input int a);
      int v;
      v = (a - 256) * 32768;
      return 24'(v);
   endfunction

   function automatic int bit_pos(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic step(input logic [7:0] kp, input logic rst);
      logic [7:0] k;
      k = kp;
      kpyd_i  = kp;
      reset_i = rst;
      @(posedge clk_i);
      if (rst) begin
         m_hex = 0; m_kv = 0; m_acc = 0; m_data = '0; m_valid = 0;
      end else begin
`ifdef KPYD_SAW_GATE_EN
         m_data = m_kv ? m_saw(m_addr()) : 24'h0;
`else
         m_data = m_saw(m_addr());
`endif
         m_acc = (m_acc + m_inc(m_hex)) % 64'h1_0000_0000;
         if ($countones(k[7:4]) == 1 && $countones(k[3:0]) == 1) begin
            m_hex = m_map[bit_pos(k[7:4]) * 4 + bit_pos(k[3:0])];
            m_kv  = 1;
         end else begin
            m_kv = 0;
         end
         m_valid = 1;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) step(8'h00, 1'b1);
      checks++;
      if ({hex_o, key_valid_o, addr_o, data_o, valid_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got hex=%h kv=%b addr=%0d data=%h valid=%b, want all 0",
                  hex_o, key_valid_o, addr_o, data_o, valid_o);
      end
      step(8'h00, 1'b0);
      checks++;
      if (hex_o !== 4'h0 || addr_o !== 9'd2 || valid_o !== 1'b1 || key_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got hex=%h addr=%0d valid=%b kv=%b, want 0 2 1 0",
                  hex_o, addr_o, valid_o, key_valid_o);
      end
   endtask

   task automatic test_key5();
      step(8'h22, 1'b0);
      checks++;
      if (hex_o !== 4'h5 || key_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL key5_decode: got hex=%h kv=%b, want 5 1", hex_o, key_valid_o);
      end
      checks++;
      if (m_inc(5) !== 64'd39370533) begin
         errors++;
         $display("FAIL key5_inc_model: got %0d, want 39370533", m_inc(5));
      end
      for (int i = 0; i < 20; i++) begin
         step(8'h22, 1'b0);
         checks++;
         if (addr_o !== 9'(m_addr()) || data_o !== m_data) begin
            errors++;
            $display("FAIL key5_ramp[%0d]: got addr=%0d data=%h, want addr=%0d data=%h",
                     i, addr_o, data_o, m_addr(), m_data);
         end
      end
   endtask

   task automatic test_illegal();
      logic [7:0] pats [2];
      pats[0] = 8'h23;
      pats[1] = 8'h00;
      for (int i = 0; i < 2; i++) begin
         step(pats[i], 1'b0);
         checks++;
         if (hex_o !== 4'h5 || key_valid_o !== 1'b0 || addr_o !== 9'(m_addr())) begin
            errors++;
            $display("FAIL illegal_%h: got hex=%h kv=%b addr=%0d, want 5 0 %0d",
                     pats[i], hex_o, key_valid_o, addr_o, m_addr());
         end
      end
   endtask

   task automatic test_key_hash();
      int prev_addr;
      int wraps;
      bit wrapped;
      wraps = 0;
      wrapped = 0;
      step(8'h84, 1'b0);
      checks++;
      if (hex_o !== 4'hF || key_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL hash_decode: got hex=%h kv=%b, want f 1", hex_o, key_valid_o);
      end
      prev_addr = int'(addr_o);
      for (int i = 0; i < 130; i++) begin
         step(i < 60 ? 8'h84 : 8'h00, 1'b0);
         checks++;
         if (addr_o !== 9'(m_addr()) || data_o !== m_data) begin
            errors++;
            $display("FAIL hash_ramp[%0d]: got addr=%0d data=%h, want addr=%0d data=%h",
                     i, addr_o, data_o, m_addr(), m_data);
         end
         if (wrapped) begin
            checks++;
`ifdef KPYD_SAW_GATE_EN
            if (data_o[23] !== 1'b1 && key_valid_o === 1'b1) begin
`else
            if (data_o[23] !== 1'b1) begin
`endif
               errors++;
               $display("FAIL hash_wrap_fall: got data=%h, want negative", data_o);
            end
         end
         wrapped = (int'(addr_o) < prev_addr);
         if (wrapped) wraps++;
         prev_addr = int'(addr_o);
      end
      checks++;
      if (wraps < 2 || wraps > 4) begin
         errors++;
         $display("FAIL hash_wrap_count: got %0d, want 2..4", wraps);
      end
      checks++;
      if (m_saw(0) !== 24'h800000 || m_saw(256) !== 24'h000000 || m_saw(511) !== 24'h7F8000) begin
         errors++;
         $display("FAIL saw_points: got %h %h %h, want 800000 000000 7f8000",
                  m_saw(0), m_saw(256), m_saw(511));
      end
   endtask

   task automatic test_random();
      logic [7:0] kp;
      logic       rst;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) kp = 8'($urandom);
         else kp = {4'(1 << $urandom_range(0, 3)), 4'(1 << $urandom_range(0, 3))};
         rst = ($urandom_range(0, 59) == 0);
         step(kp, rst);
         checks++;
         if (hex_o !== 4'(m_hex) || key_valid_o !== m_kv || addr_o !== 9'(m_addr()) ||
             data_o !== m_data || valid_o !== m_valid) begin
            errors++;
            $display("FAIL random[%0d] kp=%h rst=%b: got hex=%h kv=%b addr=%0d data=%h v=%b, want hex=%h kv=%b addr=%0d data=%h v=%b",
                     i, kp, rst, hex_o, key_valid_o, addr_o, data_o, valid_o,
                     4'(m_hex), m_kv, m_addr(), m_data, m_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 17; i++) step(8'h48, 1'b0);
      step(8'h11, 1'b1);
      checks++;
      if (addr_o !== 9'd0 || data_o !== 24'h0 || hex_o !== 4'h0 ||
          key_valid_o !== 1'b0 || valid_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got addr=%0d data=%h hex=%h kv=%b v=%b, want all 0",
                  addr_o, data_o, hex_o, key_valid_o, valid_o);
      end
      step(8'h00, 1'b0);
      checks++;
      if (addr_o !== 9'd2 || valid_o !== 1'b1 || data_o !== m_data) begin
         errors++;
         $display("FAIL reset_mid_resume: got addr=%0d v=%b data=%h, want 2 1 %h",
                  addr_o, valid_o, data_o, m_data);
      end
   endtask

   initial begin
      test_reset();
      test_key5();
      test_illegal();
      test_key_hash();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
